// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared constants and helpers for the register-file write arbiter.
// Register 0 is hard-wired to zero, so the enable decoder never selects it.
package regfile_pkg;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 1 << AW;

  function automatic logic [NREG-1:0] onehot_dec(input logic [AW-1:0] addr);
    logic [NREG-1:0] v;
    v = '0;
    if (addr != '0) v[addr] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// Requester-side write bus: flattened per-requester valid/addr/data, one-hot ready, freeze.
// The master modport is the requester side; the slave modport is the arbiter side.
interface regfile_wr_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
);

  logic                hold;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;

  modport master (
    output hold,
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  hold,
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/regfile_wr_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant starting at the pointer,
// pointer moves to the requester after the one that just transferred.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_hold,
  input  logic            i_advance,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx
);

  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_cand;
  logic          w_found;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = IW'((int'(r_ptr) + k) % NREQ);
      if (!i_hold && !w_found && i_req[w_cand]) begin
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        w_found       = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= (o_idx == IW'(NREQ - 1)) ? '0 : o_idx + IW'(1);
    end
  end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port among NREQ writeback sources.
// Outputs update on the rising edge so the falling-edge register array sees stable inputs.
module regfile_wr_arbiter
  import regfile_pkg::*;
#(
  parameter  int NREQ = 2,
  parameter  int CNTW = 16,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  regfile_wr_arbiter_if.slave    bus,
  output logic [NREG-1:0]        reg_en,
  output logic [DW-1:0]          reg_wdata,
  output logic [CNTW-1:0]        conf_cnt
);

  function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
    return (&v) ? v : v + CNTW'(1);
  endfunction

  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic [NREQ-1:0] w_ready;
  logic            w_xfer;
  logic [AW-1:0]   w_addr_p0;
  logic [DW-1:0]   w_data_p0;
  logic            w_conflict;

  logic [NREG-1:0] r_en_p1;
  logic [DW-1:0]   r_wdata_p1;
  logic [CNTW-1:0] r_conf_cnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (bus.req_valid),
    .i_hold    (bus.hold),
    .i_advance (w_xfer),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx)
  );

  // Ready is forced low during reset so nothing can appear to transfer.
  assign w_ready       = w_gnt & {NREQ{rst_n}};
  assign bus.req_ready = w_ready;
  assign w_xfer        = |w_ready;

  // p0: select the granted requester's slice
  assign w_addr_p0  = bus.req_addr[int'(w_idx)*AW +: AW];
  assign w_data_p0  = bus.req_data[int'(w_idx)*DW +: DW];
  assign w_conflict = !bus.hold && ($countones(bus.req_valid) > 1);

  // p1: write-stage register driving the register array
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_p1    <= '0;
      r_wdata_p1 <= '0;
    end else if (w_xfer) begin
      r_en_p1    <= onehot_dec(w_addr_p0);
      r_wdata_p1 <= w_data_p0;
    end else begin
      r_en_p1    <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conf_cnt <= '0;
    end else if (w_conflict) begin
      r_conf_cnt <= sat_inc(r_conf_cnt);
    end
  end

  assign reg_en    = r_en_p1;
  assign reg_wdata = r_wdata_p1;
  assign conf_cnt  = r_conf_cnt;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed-vector bench for regfile_wr_arbiter with two requesters and a 3-bit
// contention counter so saturation is reachable in a few cycles.
module tb_regfile_wr_arbiter;
  import regfile_pkg::*;

  localparam int NREQ = 2;
  localparam int CNTW = 3;

  logic            clk;
  logic            rst_n;
  logic [NREG-1:0] reg_en;
  logic [DW-1:0]   reg_wdata;
  logic [CNTW-1:0] conf_cnt;

  int n_chk;
  int n_pass;

  regfile_wr_arbiter_if #(.NREQ(NREQ)) bus ();

  regfile_wr_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .reg_en    (reg_en),
    .reg_wdata (reg_wdata),
    .conf_cnt  (conf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus.req_valid = v;
    bus.req_addr  = {a1, a0};
    bus.req_data  = {d1, d0};
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.hold = 1'b0;
    drive(2'b01, 5'd4, 32'h1, 5'd0, 32'h0);
    #3;
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_en", reg_en, 32'h0);
    chk("rst_cnt", conf_cnt, 3'd0);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    #9;
    rst_n = 1'b1;

    // Idle
    for (int i = 0; i < 3; i++) begin
      step();
      chk("idle_en", reg_en, 32'h0);
      chk("idle_ready", bus.req_ready, 2'b00);
      chk("idle_cnt", conf_cnt, 3'd0);
    end

    // Single write from requester 0
    drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
    @(negedge clk);
    chk("single_ready", bus.req_ready, 2'b01);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("single_en", reg_en, 32'h20);
    chk("single_wdata", reg_wdata, 32'hDEADBEEF);
    step();
    chk("single_clr", reg_en, 32'h0);

    // Requester 1 alone returns the pointer to 0
    drive(2'b10, 5'd0, 32'h0, 5'd3, 32'h33);
    @(negedge clk);
    chk("r1_ready", bus.req_ready, 2'b10);
    step();
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    chk("r1_en", reg_en, 32'h8);

    // Round robin, both valid for four cycles
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rr_ready", bus.req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      step();
      chk("rr_en", reg_en, (i % 2 == 0) ? 32'h2 : 32'h4);
      chk("rr_wdata", reg_wdata, (i % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    chk("rr_cnt", conf_cnt, 3'd4);

    // Requester 0 alone moves the pointer to 1, then freeze with both valid
    drive(2'b01, 5'd3, 32'h33, 5'd2, 32'hB2);
    step();
    chk("prehold_en", reg_en, 32'h8);
    drive(2'b11, 5'd1, 32'hA1, 5'd2, 32'hB2);
    bus.hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_ready", bus.req_ready, 2'b00);
      step();
      chk("hold_en", reg_en, 32'h0);
      chk("hold_cnt", conf_cnt, 3'd4);
    end
    bus.hold = 1'b0;
    @(negedge clk);
    chk("posthold_ready", bus.req_ready, 2'b10);
    step();
    chk("posthold_en", reg_en, 32'h4);
    chk("posthold_cnt", conf_cnt, 3'd5);
    drive(2'b01, 5'd1, 32'hA1, 5'd0, 32'h0);
    @(negedge clk);
    chk("posthold_ready0", bus.req_ready, 2'b01);
    step();
    chk("posthold_en0", reg_en, 32'h2);
    chk("posthold_cnt0", conf_cnt, 3'd5);

    // Write to register 0 from requester 1
    drive(2'b10, 5'd0, 32'h0, 5'd0, 32'h1234);
    @(negedge clk);
    chk("zero_ready", bus.req_ready, 2'b10);
    step();
    chk("zero_en", reg_en, 32'h0);
    chk("zero_wdata", reg_wdata, 32'h1234);

    // Pointer back at 0, then reset while reg_en is live
    drive(2'b11, 5'd3, 32'h88, 5'd9, 32'h99);
    @(negedge clk);
    chk("ptr0_ready", bus.req_ready, 2'b01);
    step();
    chk("midw_en", reg_en, 32'h8);
    chk("midw_wdata", reg_wdata, 32'h88);
    chk("midw_cnt", conf_cnt, 3'd6);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_en", reg_en, 32'h0);
    chk("async_wdata", reg_wdata, 32'h0);
    chk("async_cnt", conf_cnt, 3'd0);
    chk("async_ready", bus.req_ready, 2'b00);
    step();
    chk("inrst_en", reg_en, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", bus.req_ready, 2'b01);
    step();
    chk("rel_en", reg_en, 32'h8);
    chk("rel_cnt", conf_cnt, 3'd1);

    // Counter saturation
    for (int i = 0; i < 8; i++) step();
    chk("sat_cnt", conf_cnt, 3'd7);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
    step();
    chk("sat_hold", conf_cnt, 3'd7);
    chk("sat_en", reg_en, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
